// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the asynchronous FIFO.
// The read-side controller reuses the helpers; the write side uses gray_to_bin directly.
package async_fifo_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] gray);
    logic [PTR_WIDTH-1:0] bin;
    bin[PTR_WIDTH-1] = gray[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_to_bin
  import async_fifo_pkg::*;
#(
  parameter int W = PTR_WIDTH
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o[W-1] = gray_i[W-1];

  generate
    for (genvar gi = W - 2; gi >= 0; gi--) begin : g_chain
      assign bin_o[gi] = bin_o[gi+1] ^ gray_i[gi];
    end
  endgenerate

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side controller of the asynchronous FIFO: write address/enable, Gray
// write pointer, and full / almost-full / level / overflow status.
module wptr_full_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = async_fifo_pkg::ADDR_WIDTH,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  wafull,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  wovf
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wcount_q, wcount_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;
  logic [PW-1:0] rbin_sync;

  gray_to_bin #(.W(PW)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin_sync)
  );

  // Gating with reset keeps the RAM from being written while held in reset.
  assign wen = winc & ~wfull_q & wrst_n;

  always_comb begin
    wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
    wptr_d   = wbin_d ^ (wbin_d >> 1);
    // Full when the two MSBs differ and the rest match the synchronized read pointer.
    wfull_d  = (wptr_d == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
    wcount_d = wbin_d - rbin_sync;
    wafull_d = (wcount_d >= PW'(AF_LEVEL));
    wovf_d   = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wcount_q <= wcount_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr  = wbin_q[ADDR_WIDTH-1:0];
  assign wptr   = wptr_q;
  assign wfull  = wfull_q;
  assign wafull = wafull_q;
  assign wcount = wcount_q;
  assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: a fill/occupancy model pushes expected
// post-edge state into a queue, which is popped and compared after each edge.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [3:0] wcount;
  logic       wovf;

  wptr_full_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(6)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wafull   (wafull),
    .wcount   (wcount),
    .wovf     (wovf)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic [3:0] cnt;
    logic       full;
    logic       afull;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Model: number of accepted writes and reads, both modulo 16.
  logic [3:0] m_wbin;
  logic [3:0] m_rbin;
  logic       m_full;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wbin = '0;
    m_rbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wen"},    32'(wen),    32'd0);
    chk({tag, "_waddr"},  32'(waddr),  32'd0);
    chk({tag, "_wptr"},   32'(wptr),   32'd0);
    chk({tag, "_wfull"},  32'(wfull),  32'd0);
    chk({tag, "_wafull"}, 32'(wafull), 32'd0);
    chk({tag, "_wcount"}, 32'(wcount), 32'd0);
    chk({tag, "_wovf"},   32'(wovf),   32'd0);
  endtask

  // One clock: drive winc and a read pointer (given in binary, sent as Gray),
  // check the combinational write enable and address, then the registered state.
  task automatic cycle(input logic w, input logic [3:0] rb);
    logic       acc;
    logic [3:0] nb;
    logic [3:0] cnt;
    exp_t       e;
    exp_t       got;
    @(negedge wclk);
    winc     = w;
    wq2_rptr = to_gray(rb);
    acc = w & ~m_full;
    #1;
    chk("wen",       32'(wen),   32'(acc));
    chk("waddr_pre", 32'(waddr), 32'(m_wbin[2:0]));
    nb  = m_wbin + 4'(acc);
    cnt = nb - rb;
    e.wptr  = to_gray(nb);
    e.waddr = nb[2:0];
    e.cnt   = cnt;
    e.full  = (cnt == 4'd8);
    e.afull = (cnt >= 4'd6);
    e.ovf   = m_ovf | (w & m_full);
    sb.push_back(e);
    m_wbin = nb;
    m_rbin = rb;
    m_full = e.full;
    m_ovf  = e.ovf;
    @(posedge wclk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      n_txn++;
      $display("txn %0d winc=%0b rptr=%b wptr=%b waddr=%0d wcount=%0d wfull=%0b wafull=%0b wovf=%0b",
               n_txn, w, wq2_rptr, wptr, waddr, wcount, wfull, wafull, wovf);
      chk("wptr",   32'(wptr),   32'(got.wptr));
      chk("waddr",  32'(waddr),  32'(got.waddr));
      chk("wcount", 32'(wcount), 32'(got.cnt));
      chk("wfull",  32'(wfull),  32'(got.full));
      chk("wafull", 32'(wafull), 32'(got.afull));
      chk("wovf",   32'(wovf),   32'(got.ovf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_wptr;
    logic [3:0] hist0;
    logic [3:0] hist1;

    // Reset held with a pending write request.
    wrst_n   = 1'b0;
    winc     = 1'b1;
    wq2_rptr = '0;
    model_reset();
    repeat (3) begin
      @(posedge wclk);
      #1;
      check_all_zero("rst_hold");
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    winc   = 1'b0;

    // Reset asserted in the middle of a burst clears state without a clock edge.
    repeat (3) cycle(1'b1, 4'd0);
    @(negedge wclk);
    winc = 1'b1;
    #2;
    wrst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge wclk);
    wrst_n = 1'b1;
    winc   = 1'b0;
    model_reset();

    // Fill: 8 writes with the read pointer at zero.
    repeat (8) cycle(1'b1, 4'd0);
    chk("fill_wptr", 32'(wptr), 32'b1100);

    // Overflow: writes while full are dropped, wovf is sticky.
    repeat (3) cycle(1'b1, 4'd0);
    repeat (20) cycle(1'b0, 4'd0);

    // Drain: read pointer 1, 2, 3 (Gray 0001, 0011, 0010).
    cycle(1'b0, 4'd1);
    cycle(1'b0, 4'd2);
    cycle(1'b0, 4'd3);

    // Simultaneous write and read-pointer advance at a level of 5.
    cycle(1'b1, 4'd4);

    // Empty the FIFO, then stream 40 writes with the reader two cycles behind.
    cycle(1'b0, m_wbin);
    hist0     = m_wbin;
    hist1     = m_wbin;
    prev_wptr = wptr;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, hist1);
      hist1 = hist0;
      hist0 = m_wbin;
      chk("gray_one_bit", 32'($countones(prev_wptr ^ wptr)), 32'd1);
      prev_wptr = wptr;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side controller for the 8-entry asynchronous FIFO. It runs entirely in the write clock domain and accepts write requests from the producer. It drives the dual-port RAM write address and write enable, publishes a Gray-coded write pointer for the read-domain synchronizer, and generates full, almost-full, fill-level and overflow status from the two-flop-synchronized read pointer.

## Interface
- ADDR_WIDTH, 3: RAM address bits; depth DEPTH = 2**ADDR_WIDTH = 8; pointers are ADDR_WIDTH+1 bits.
- AF_LEVEL, 6: fill level at or above which wafull asserts; legal range 1..DEPTH.

- wclk  in  1  write clock; the only clock. All state updates on its rising edge.
- wrst_n  in  1  reset, asynchronous, active-low.
- winc  in  1  producer write request for this cycle.
- wq2_rptr  in  ADDR_WIDTH+1  read pointer, Gray-coded, already synchronized into wclk by a two-flop synchronizer.
- wen  out  1  RAM write enable.
- waddr  out  ADDR_WIDTH  RAM write address.
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- wfull  out  1  FIFO full, registered.
- wafull  out  1  almost full, registered.
- wcount  out  ADDR_WIDTH+1  registered fill level as seen from the write domain, 0..DEPTH.
- wovf  out  1  sticky overflow: set when winc=1 while wfull=1.

## Operation
- State: binary pointer wbin (ADDR_WIDTH+1 bits), wptr, wfull, wafull, wcount, wovf.
- wen = winc & ~wfull, combinational. This is the only combinational path from an input to an output.
- waddr = wbin[ADDR_WIDTH-1:0]. It comes straight from a register.
- Next pointer: wbin_next = wbin + wen, wrapping modulo 2**(ADDR_WIDTH+1). wgray_next = wbin_next ^ (wbin_next >> 1).
- Full: wfull_next = (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
- Level: rbin_sync = gray-to-binary(wq2_rptr). wcount_next = wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1).
- Almost full: wafull_next = (wcount_next >= AF_LEVEL).
- Consistency rule: wfull=1 exactly when wcount==DEPTH, in every cycle.
- Overflow: a write attempted while full is dropped, with no pointer movement. wovf sets and holds until reset.
- Read pointer stepping backward or jumping more than DEPTH (illegal input): no protection; behaviour is undefined and is not checked.

## Timing
- Reset (wrst_n=0, asynchronous): wbin=0, wptr=0, wfull=0, wafull=0, wcount=0, wovf=0. waddr reads 0 immediately.
- Outputs are valid from the first wclk edge after reset deasserts.
- Reset asserted mid-operation clears all state immediately. The read side must be reset together with it; a stale wq2_rptr after reset is the integrator's responsibility.
- Write latency: with winc=1 and wfull=0 at edge N, the RAM captures data at address waddr on edge N. On the same edge, wbin, wptr and wcount advance by one.
- Full assertion: the write that fills the FIFO sets wfull on the same edge the write occurs. A back-to-back winc on the next cycle is blocked.
- Full deassertion is pessimistic. It occurs one wclk after a changed wq2_rptr is presented, which is two or more wclk edges after the actual read because of the synchronizer.
- Wrap-around: after 16 writes with matching reads, wbin returns to 0. The Gray pointer changes exactly one bit per increment.
- Simultaneous write and read-pointer advance in one cycle: wcount is unchanged and wfull is recomputed correctly.

## Structure
- Shared package async_fifo_pkg holds:
  - ADDR_WIDTH default constant
  - DEPTH
  - pointer width
  - bin2gray and gray2bin functions, for reuse by the read-side controller.
- One sub-module, gray_to_bin: a parameterized combinational converter (XOR prefix chain), instantiated for wq2_rptr.
- The rest stays flat.

## Test plan
- Reset: hold wrst_n=0 with winc=1 -> all outputs 0, wen=0 until release. Then assert reset mid-burst -> outputs clear without waiting for a clock edge.
- Fill: wq2_rptr=0, winc=1 for 8 cycles -> waddr 0..7, wcount 1..8, wafull rises after the 6th write, wfull rises after the 8th write, wptr=4'b1100.
- Overflow: from full, winc=1 for 3 more cycles -> wen=0, waddr stays 0, wptr unchanged, wovf=1 and stays 1 through 20 idle cycles.
- Drain: from full, step wq2_rptr 0000->0001->0011 -> wfull clears one cycle after 0001 is applied, wcount 7 then 6, wafull clears when wcount falls to 5.
- Wrap: stream 40 writes with wq2_rptr tracking two cycles behind -> wbin wraps twice, wfull never asserts, each wptr change flips exactly one bit.
- Simultaneous: at wcount=5, apply winc=1 and a one-step wq2_rptr advance in the same cycle -> wcount remains 5, wfull=0.
